branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Consumer end of the ALU condition flags: resolves conditional branches and jumps against the 5-bit flag word the ALU produces, and owns the program counter.
- Sits between decode and the fetch address mux. Accepts one control-flow op at a time over a valid/ready handshake.
- Outputs the next PC, a link value for JAL, and one-cycle taken/flush pulses.

Parameters:
- WIDTH, 16, datapath and PC width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- flags  input  5  ALU flag word: bit0 C, bit1 L, bit2 F, bit3 Z, bit4 N.
- op_valid  input  1  decode presents an op.
- op_ready  output  1  unit can accept an op.
- op  input  2  00 SEQ (pc+1), 01 BCOND (pc+disp), 10 JCOND (pc=target), 11 JAL (link, pc=target).
- cond  input  4  condition code for BCOND/JCOND.
- disp  input  8  signed displacement for BCOND.
- target  input  WIDTH  absolute target for JCOND/JAL.
- stall  input  1  fetch not ready; hold the commit.
- pc  output  WIDTH  current program counter.
- link  output  WIDTH  return address (pc+1), valid while link_we is high.
- link_we  output  1  one-cycle register-file write strobe for JAL.
- taken  output  1  one-cycle pulse: the committed op redirected the PC.
- flush  output  1  one-cycle pulse, equal to taken; fetch discards its in-flight word.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, pc=RESET_PC, op_ready=1, link=0, link_we=0, taken=0, flush=0.
- FSM states are IDLE and RESOLVE.
- IDLE: op_ready=1. On a rising edge with op_valid=1, the unit latches op, cond, disp, target and flags, and moves to RESOLVE. op_ready drops to 0 the next cycle.
- RESOLVE: op_ready=0. Evaluates cond against the latched flags only; later flag changes are ignored.
  - stall=1: the unit holds RESOLVE with no pc update and no pulses.
  - stall=0: on the next edge pc updates, the pulses assert for exactly one cycle, and the FSM returns to IDLE.
- Latency: op accepted at edge E. pc, taken, flush and link_we are visible after edge E+1, plus one cycle per stall cycle. Throughput is one op per 2 cycles.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - A LO: !L&!Z
  - B HS: L|Z
  - C LT: !N&!Z
  - D GE: N|Z
  - E UC: 1
  - F NV: 0
- Next PC:
  - SEQ: pc+1. taken=0 and cond is ignored.
  - BCOND: if true, pc + sign_extend(disp), else pc+1.
  - JCOND: if true, target, else pc+1.
  - JAL: always target; link=pc+1 (the pre-update pc), link_we=1. cond is ignored.
- Arithmetic is modulo 2^WIDTH: pc=FFFF with SEQ gives 0000; pc=0002 with disp=FC gives FFFE.
- taken=1 only when the committed pc differs from the sequential path, i.e. a true BCOND/JCOND or any JAL. A true BCOND with disp=+1 still asserts taken.
- link holds its value after link_we falls, until the next JAL.
- op_valid while op_ready=0 is ignored. Decode must hold the op until accepted.
- Reset asserted in RESOLVE discards the op; no pulses are emitted.

Optional Feature:
- Macro: BRANCH_PC_STATS_EN.
- Defined: adds outputs taken_cnt[15:0] and nottaken_cnt[15:0].
  - Counts committed BCOND/JCOND ops by outcome.
  - Counters saturate at FFFF and clear on reset.
  - SEQ and JAL are not counted.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then SEQ three times, stall=0 -> pc goes 0000, 0001, 0002, 0003; taken never asserts; op_ready pattern 1,0,1,0.
- BCOND cond=0 (EQ), flags=01000 (Z=1), disp=F0, pc=0020 -> pc=0010; taken=1 and flush=1 for one cycle. Repeat with flags=00000 -> pc=0021, taken=0.
- JAL target=1234 at pc=0050 -> pc=1234, link=0051, link_we=1 for one cycle; then JCOND cond=F (NV) -> pc=1235, taken=0.
- JCOND cond=A (LO), flags=00000, target=ABCD; flags change to 00010 during RESOLVE; stall=1 for 3 cycles -> pc stays fixed for 3 cycles, then becomes ABCD (latched flags win); op_ready stays 0 throughout.
- Wrap: pc=FFFF with SEQ -> 0000. pc=0002 with BCOND UC and disp=FC -> FFFE.
- Reset pulsed low mid-RESOLVE -> pc=RESET_PC immediately with no pulses. With BRANCH_PC_STATS_EN: 2 taken plus 1 not-taken -> taken_cnt=2, nottaken_cnt=1.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Branch/jump resolver and program-counter owner: one control-flow op per 2 cycles.
// Optional BRANCH_PC_STATS_EN adds saturating taken/not-taken counters for BCOND/JCOND.
module branch_pc_unit #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       flags,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op,
  input  logic [3:0]       cond,
  input  logic [7:0]       disp,
  input  logic [WIDTH-1:0] target,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] link,
  output logic             link_we,
  output logic             taken,
`ifdef BRANCH_PC_STATS_EN
  output logic [15:0]      taken_cnt,
  output logic [15:0]      nottaken_cnt,
`endif
  output logic             flush
);

  typedef enum logic {IDLE, RESOLVE} state_t;
  typedef enum logic [1:0] {OP_SEQ, OP_BCOND, OP_JCOND, OP_JAL} op_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [3:0]       cond;
    logic [7:0]       disp;
    logic [WIDTH-1:0] target;
    logic [4:0]       flags;
  } req_t;

  state_t state, state_n;
  req_t   req;

  // flag word: {N, Z, F, L, C}
  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
    logic fc, fl, ff, fz, fn;
    {fn, fz, ff, fl, fc} = f;
    case (c)
      4'h0: cond_true = fz;
      4'h1: cond_true = !fz;
      4'h2: cond_true = fc;
      4'h3: cond_true = !fc;
      4'h4: cond_true = fl;
      4'h5: cond_true = !fl;
      4'h6: cond_true = fn;
      4'h7: cond_true = !fn;
      4'h8: cond_true = ff;
      4'h9: cond_true = !ff;
      4'hA: cond_true = !fl && !fz;
      4'hB: cond_true = fl || fz;
      4'hC: cond_true = !fn && !fz;
      4'hD: cond_true = fn || fz;
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  endfunction

  logic             accept, commit, redirect, is_br;
  logic [WIDTH-1:0] pc_seq, pc_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    op_ready = 1'b0;
    accept   = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        accept   = op_valid;
        if (op_valid) state_n = RESOLVE;
      end
      RESOLVE: begin
        commit = !stall;
        if (!stall) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    pc_seq   = pc + WIDTH'(1);
    pc_n     = pc_seq;
    redirect = 1'b0;
    is_br    = (req.op == OP_BCOND) || (req.op == OP_JCOND);
    case (op_t'(req.op))
      OP_BCOND: begin
        redirect = cond_true(req.cond, req.flags);
        if (redirect) pc_n = pc + {{(WIDTH-8){req.disp[7]}}, req.disp};
      end
      OP_JCOND: begin
        redirect = cond_true(req.cond, req.flags);
        if (redirect) pc_n = req.target;
      end
      OP_JAL: begin
        redirect = 1'b1;
        pc_n     = req.target;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req     <= '0;
      pc      <= RESET_PC;
      link    <= '0;
      link_we <= 1'b0;
      taken   <= 1'b0;
      flush   <= 1'b0;
    end else begin
      link_we <= 1'b0;
      taken   <= 1'b0;
      flush   <= 1'b0;
      if (accept) req <= '{op: op, cond: cond, disp: disp, target: target, flags: flags};
      if (commit) begin
        pc    <= pc_n;
        taken <= redirect;
        flush <= redirect;
        if (req.op == OP_JAL) begin
          link    <= pc_seq;
          link_we <= 1'b1;
        end
      end
    end
  end

`ifdef BRANCH_PC_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_cnt    <= '0;
      nottaken_cnt <= '0;
    end else if (commit && is_br) begin
      if (redirect && taken_cnt != 16'hFFFF)         taken_cnt    <= taken_cnt + 16'd1;
      if (!redirect && nottaken_cnt != 16'hFFFF)     nottaken_cnt <= nottaken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: hand-computed PC/pulse expectations per op.
module tb_branch_pc_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  flags;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op;
  logic [3:0]  cond;
  logic [7:0]  disp;
  logic [15:0] target;
  logic        stall;
  logic [15:0] pc, link;
  logic        link_we, taken, flush;
`ifdef BRANCH_PC_STATS_EN
  logic [15:0] taken_cnt, nottaken_cnt;
`endif

  int n_chk = 0;
  int n_ok  = 0;

  always #5 clk = ~clk;

  branch_pc_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .flags(flags), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .cond(cond), .disp(disp), .target(target), .stall(stall),
    .pc(pc), .link(link), .link_we(link_we), .taken(taken),
`ifdef BRANCH_PC_STATS_EN
    .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt),
`endif
    .flush(flush)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // present op for one accept edge; unit is in RESOLVE on return
  task automatic send(input logic [1:0] o, input logic [3:0] c, input logic [7:0] d,
                      input logic [15:0] t, input logic [4:0] f);
    op = o; cond = c; disp = d; target = t; flags = f; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
  endtask

  task automatic run(input logic [1:0] o, input logic [3:0] c, input logic [7:0] d,
                     input logic [15:0] t, input logic [4:0] f);
    send(o, c, d, t, f);
    step();
  endtask

  initial begin
    reset = 1'b0; flags = '0; op_valid = 1'b0; op = '0; cond = '0; disp = '0;
    target = '0; stall = 1'b0;
    #12;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ready", 16'(op_ready), 16'd1);
    chk("rst_pulses", {13'd0, taken, flush, link_we}, 16'd0);
    chk("rst_link", link, 16'h0000);
    reset = 1'b1;
    step();

    // three sequential ops
    for (int i = 1; i <= 3; i++) begin
      chk("seq_ready_idle", 16'(op_ready), 16'd1);
      send(2'b00, 4'hE, 8'h00, 16'h0000, 5'b0);
      chk("seq_ready_busy", 16'(op_ready), 16'd0);
      step();
      chk("seq_pc", pc, 16'(i));
      chk("seq_taken", 16'(taken), 16'd0);
    end

    // BCOND EQ true, backward displacement
    run(2'b10, 4'hE, 8'h00, 16'h0020, 5'b0);
    run(2'b01, 4'h0, 8'hF0, 16'h0000, 5'b01000);
    chk("beq_pc", pc, 16'h0010);
    chk("beq_taken", 16'(taken), 16'd1);
    chk("beq_flush", 16'(flush), 16'd1);
    step();
    chk("beq_pulse_end", {14'd0, taken, flush}, 16'd0);
    run(2'b10, 4'hE, 8'h00, 16'h0020, 5'b0);
    run(2'b01, 4'h0, 8'hF0, 16'h0000, 5'b00000);
    chk("beq_nt_pc", pc, 16'h0021);
    chk("beq_nt_taken", 16'(taken), 16'd0);

    // JAL then JCOND NV
    run(2'b10, 4'hE, 8'h00, 16'h0050, 5'b0);
    run(2'b11, 4'hF, 8'h00, 16'h1234, 5'b0);
    chk("jal_pc", pc, 16'h1234);
    chk("jal_link", link, 16'h0051);
    chk("jal_we", 16'(link_we), 16'd1);
    chk("jal_taken", 16'(taken), 16'd1);
    step();
    chk("jal_we_end", 16'(link_we), 16'd0);
    chk("jal_link_hold", link, 16'h0051);
    run(2'b10, 4'hF, 8'h00, 16'hAAAA, 5'b11111);
    chk("jnv_pc", pc, 16'h1235);
    chk("jnv_taken", 16'(taken), 16'd0);

    // JCOND LO with stall and late flag change
    send(2'b10, 4'hA, 8'h00, 16'hABCD, 5'b00000);
    stall = 1'b1;
    flags = 5'b00010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 16'h1235);
      chk("stall_ready", 16'(op_ready), 16'd0);
      chk("stall_taken", 16'(taken), 16'd0);
    end
    stall = 1'b0;
    step();
    chk("lo_pc", pc, 16'hABCD);
    chk("lo_taken", 16'(taken), 16'd1);

    // wrap-around
    run(2'b10, 4'hE, 8'h00, 16'hFFFF, 5'b0);
    run(2'b00, 4'h0, 8'h00, 16'h0000, 5'b0);
    chk("wrap_seq", pc, 16'h0000);
    run(2'b10, 4'hE, 8'h00, 16'h0002, 5'b0);
    run(2'b01, 4'hE, 8'hFC, 16'h0000, 5'b0);
    chk("wrap_bcond", pc, 16'hFFFE);
    run(2'b01, 4'hE, 8'h01, 16'h0000, 5'b0);
    chk("disp1_pc", pc, 16'hFFFF);
    chk("disp1_taken", 16'(taken), 16'd1);

    // reset during RESOLVE
    send(2'b10, 4'hE, 8'h00, 16'h5555, 5'b0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_pulses", {14'd0, taken, flush}, 16'd0);
    #2 reset = 1'b1;
    step();
    chk("post_rst_pc", pc, 16'h0000);
    chk("post_rst_taken", 16'(taken), 16'd0);
    chk("post_rst_ready", 16'(op_ready), 16'd1);

    // branch outcome mix: 2 taken, 1 not-taken, plus uncounted SEQ/JAL
    run(2'b01, 4'hE, 8'h05, 16'h0000, 5'b0);
    chk("mix_b1", pc, 16'h0005);
    run(2'b01, 4'hF, 8'h05, 16'h0000, 5'b0);
    chk("mix_b2", pc, 16'h0006);
    run(2'b10, 4'h2, 8'h00, 16'h0100, 5'b00001);
    chk("mix_j", pc, 16'h0100);
    run(2'b00, 4'hE, 8'h00, 16'h0000, 5'b0);
    run(2'b11, 4'h0, 8'h00, 16'h0200, 5'b0);
    chk("mix_jal_link", link, 16'h0102);
`ifdef BRANCH_PC_STATS_EN
    chk("taken_cnt", taken_cnt, 16'd2);
    chk("nottaken_cnt", nottaken_cnt, 16'd1);
`endif

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
